// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds opcode/funct encodings, ALU control codes, the FSM state encoding,
// trap cause codes and the bundle of datapath control strobes.
package mips_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  // Every per-cycle control output of the unit, so it can be zeroed as one
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_en;
    logic       rf_we;
    logic       retire;
    logic       sel_result;
    logic       sel_pc;
    logic       sel_alu_b;
    logic       sel_wa;
    logic       sel_jump;
    logic [2:0] alu_ctrl;
  } ctl_t;

  // Opcodes whose second ALU operand is the sign-extended immediate
  function automatic logic uses_immediate(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decoder.
// Ports:
//   opcode   in  6  latched instruction[31:26]
//   funct    in  6  latched instruction[5:0]
//   alu_ctrl out 3  ALU operation for the EXEC state
//   illegal  out 1  opcode unknown, or R-type with an unsupported funct
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  // Map the instruction class to an ALU operation and flag anything unsupported
  always_comb begin
    alu_ctrl = ALU_AND;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: illegal  = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_ctrl = ALU_ADD;
      OP_BEQ:                alu_ctrl = ALU_SUB;
      OP_J:                  alu_ctrl = ALU_AND;
      default:               illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ready handshakes to instruction and data memory, and traps (sticky)
// on illegal instructions or memory timeouts.
// Ports:
//   clock, reset (sync, active-high)
//   instruction[31:0], zero, imem_ready, dmem_ready        inputs
//   imem_req, dmem_req, dmem_we                             memory requests
//   pc_en, rf_we, retire                                    one-cycle strobes
//   sel_result, sel_pc, sel_alu_b, sel_wa, sel_jump         datapath selects
//   alu_ctrl[2:0], err[1:0], state[2:0]                     ALU op, trap cause, debug state
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_en,
  output logic        rf_we,
  output logic        sel_result,
  output logic        sel_pc,
  output logic        sel_alu_b,
  output logic        sel_wa,
  output logic        sel_jump,
  output logic [2:0]  alu_ctrl,
  output logic        retire,
  output logic [1:0]  err,
  output logic [2:0]  state
);

  // Counter value seen in the WAIT_LIMIT-th consecutive not-ready cycle
  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_t     cur;
  state_t     nxt;
  err_t       err_code;
  err_t       trap_code;
  logic [7:0] wait_cnt;
  logic [5:0] op;
  logic [5:0] fn;
  logic [2:0] dec_alu;
  logic       dec_illegal;
  logic       is_r;
  logic       is_lw;
  logic       is_sw;
  logic       uses_imm;
  ctl_t       ctl;
  ctl_t       ctl_out;
  logic       unused_instr;

  // Only opcode and funct matter to control; fold the rest away
  assign unused_instr = ^instruction[25:6];

  assign is_r     = (op == OP_RTYPE);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign uses_imm = uses_immediate(op);

  alu_decoder u_alu_decoder (
    .opcode   (op),
    .funct    (fn),
    .alu_ctrl (dec_alu),
    .illegal  (dec_illegal)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Trap cause is captured on the transition into TRAP and then held
  always_ff @(posedge clock) begin
    if (reset)                                 err_code <= ERR_NONE;
    else if ((nxt == S_TRAP) && (cur != S_TRAP)) err_code <= trap_code;
    else                                       err_code <= err_code;
  end

  // Opcode/funct are latched on the accepted fetch so decode sees a stable copy
  always_ff @(posedge clock) begin
    if (reset) begin
      op <= 6'd0;
      fn <= 6'd0;
    end else if ((cur == S_FETCH) && imem_ready) begin
      op <= instruction[31:26];
      fn <= instruction[5:0];
    end else begin
      op <= op;
      fn <= fn;
    end
  end

  // Wait counter: restarts on every state change, counts not-ready request cycles
  always_ff @(posedge clock) begin
    if (reset)                                  wait_cnt <= 8'd0;
    else if (nxt != cur)                        wait_cnt <= 8'd0;
    else if (((cur == S_FETCH) && !imem_ready) ||
             ((cur == S_MEM) && !dmem_ready))   wait_cnt <= wait_cnt + 8'd1;
    else                                        wait_cnt <= wait_cnt;
  end

  // Next-state and control decode
  always_comb begin
    nxt       = cur;
    trap_code = ERR_NONE;
    ctl       = '0;

    // Opcode-derived selects hold for the whole body of a legal instruction
    if ((cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) && !dec_illegal) begin
      ctl.sel_alu_b = uses_imm;
      ctl.sel_wa    = is_r;
      ctl.sel_result = is_lw;
      ctl.alu_ctrl  = uses_imm ? ALU_ADD : ALU_AND;
    end else begin
      ctl.alu_ctrl  = ALU_AND;
    end

    case (cur)
      S_FETCH: begin
        ctl.imem_req = 1'b1;
        // Ready on the limit cycle still wins over the timeout
        if (imem_ready) begin
          nxt = S_DECODE;
        end else if (wait_cnt == LAST_WAIT) begin
          nxt       = S_TRAP;
          trap_code = ERR_TIMEOUT;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          nxt       = S_TRAP;
          trap_code = ERR_ILLEGAL;
        end else if (op == OP_J) begin
          ctl.sel_jump = 1'b1;
          ctl.pc_en    = 1'b1;
          ctl.retire   = 1'b1;
          nxt          = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        ctl.alu_ctrl = dec_alu;
        if (op == OP_BEQ) begin
          ctl.sel_pc = zero;
          ctl.pc_en  = 1'b1;
          ctl.retire = 1'b1;
          nxt        = S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        ctl.dmem_req = 1'b1;
        ctl.dmem_we  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            ctl.pc_en  = 1'b1;
            ctl.retire = 1'b1;
            nxt        = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (wait_cnt == LAST_WAIT) begin
          nxt       = S_TRAP;
          trap_code = ERR_TIMEOUT;
        end else begin
          nxt = S_MEM;
        end
      end
      S_WB: begin
        ctl.rf_we  = 1'b1;
        ctl.pc_en  = 1'b1;
        ctl.retire = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP: begin
        nxt = S_TRAP;
      end
      default: begin
        // Unused encodings are treated as a corrupted state and parked in TRAP
        nxt       = S_TRAP;
        trap_code = ERR_ILLEGAL;
      end
    endcase
  end

  // Nothing is driven towards the datapath or memories while reset is held
  assign ctl_out    = reset ? '0 : ctl;

  assign imem_req   = ctl_out.imem_req;
  assign dmem_req   = ctl_out.dmem_req;
  assign dmem_we    = ctl_out.dmem_we;
  assign pc_en      = ctl_out.pc_en;
  assign rf_we      = ctl_out.rf_we;
  assign retire     = ctl_out.retire;
  assign sel_result = ctl_out.sel_result;
  assign sel_pc     = ctl_out.sel_pc;
  assign sel_alu_b  = ctl_out.sel_alu_b;
  assign sel_wa     = ctl_out.sel_wa;
  assign sel_jump   = ctl_out.sel_jump;
  assign alu_ctrl   = ctl_out.alu_ctrl;
  assign err        = err_code;
  assign state      = cur;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control. Expected per-cycle output vectors are
// queued when an instruction is issued and popped as each cycle is sampled.
module tb_mips_mc_control;

  localparam int WL = 4;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_T = 3'd7;

  // Flag order: imem_req dmem_req dmem_we pc_en rf_we retire sel_result sel_pc sel_alu_b sel_wa sel_jump
  localparam logic [10:0] F_NONE = 11'b000_0000_0000;
  localparam logic [10:0] F_IREQ = 11'b100_0000_0000;
  localparam logic [10:0] F_DREQ = 11'b010_0000_0000;
  localparam logic [10:0] F_DWE  = 11'b001_0000_0000;
  localparam logic [10:0] F_PC   = 11'b000_1000_0000;
  localparam logic [10:0] F_RF   = 11'b000_0100_0000;
  localparam logic [10:0] F_RET  = 11'b000_0010_0000;
  localparam logic [10:0] F_RES  = 11'b000_0001_0000;
  localparam logic [10:0] F_SPC  = 11'b000_0000_1000;
  localparam logic [10:0] F_ALUB = 11'b000_0000_0100;
  localparam logic [10:0] F_WA   = 11'b000_0000_0010;
  localparam logic [10:0] F_JMP  = 11'b000_0000_0001;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, dmem_we, pc_en, rf_we, retire;
  logic        sel_result, sel_pc, sel_alu_b, sel_wa, sel_jump;
  logic [2:0]  alu_ctrl;
  logic [1:0]  err;
  logic [2:0]  state;

  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  mips_mc_control #(.WAIT_LIMIT(WL)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .pc_en       (pc_en),
    .rf_we       (rf_we),
    .sel_result  (sel_result),
    .sel_pc      (sel_pc),
    .sel_alu_b   (sel_alu_b),
    .sel_wa      (sel_wa),
    .sel_jump    (sel_jump),
    .alu_ctrl    (alu_ctrl),
    .retire      (retire),
    .err         (err),
    .state       (state)
  );

  function automatic logic [18:0] mk(input logic [2:0] st, input logic [10:0] f,
                                     input logic [2:0] alu, input logic [1:0] e);
    return {st, f, alu, e};
  endfunction

  function automatic logic [31:0] r_ins(input logic [5:0] f);
    return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] o);
    return {o, 5'd4, 5'd5, 16'h0010};
  endfunction

  task automatic push(input string t, input logic [18:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Drive one cycle of inputs, sample at the falling edge, compare with queue head
  task automatic step(input logic ir, input logic dr, input logic rst);
    logic [18:0] obs;
    logic [18:0] e;
    string       t;
    imem_ready = ir;
    dmem_ready = dr;
    reset      = rst;
    @(negedge clock);
    obs = {state, imem_req, dmem_req, dmem_we, pc_en, rf_we, retire,
           sel_result, sel_pc, sel_alu_b, sel_wa, sel_jump, alu_ctrl, err};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  // One reset cycle: outputs silent, state/err still show the pre-reset values
  task automatic reset_cycle(input string t, input logic [2:0] st, input logic [1:0] e);
    push(t, mk(st, F_NONE, 3'b000, e));
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Issue one instruction: queue expected cycles from the timing model, then run them
  task automatic run_instr(input string t, input logic [31:0] ins, input int iw,
                           input int dw, input logic z);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        is_r, is_lw, is_sw, is_addi, is_beq, is_j, legal;
    logic [2:0]  ex_alu, st_alu;
    logic [10:0] s;
    logic        ir, dr;
    int          n, mem_start;
    op      = ins[31:26];
    fn      = ins[5:0];
    is_r    = (op == 6'b000000);
    is_j    = (op == 6'b000010);
    is_beq  = (op == 6'b000100);
    is_addi = (op == 6'b001000);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    legal   = (is_r && (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}))
              || is_j || is_beq || is_addi || is_lw || is_sw;
    ex_alu  = 3'b000;
    if (is_r) begin
      case (fn)
        6'b100000: ex_alu = 3'b010;
        6'b100010: ex_alu = 3'b110;
        6'b100100: ex_alu = 3'b000;
        6'b100101: ex_alu = 3'b001;
        6'b101010: ex_alu = 3'b111;
        default:   ex_alu = 3'b000;
      endcase
    end else if (is_beq) ex_alu = 3'b110;
    else if (is_lw || is_sw || is_addi) ex_alu = 3'b010;
    st_alu = (is_lw || is_sw || is_addi) ? 3'b010 : 3'b000;
    s = ((is_lw || is_sw || is_addi) ? F_ALUB : F_NONE) | (is_r ? F_WA : F_NONE) |
        (is_lw ? F_RES : F_NONE);

    for (int k = 0; k <= iw; k++) push({t, "_fetch"}, mk(ST_F, F_IREQ, 3'b000, 2'b00));
    if (!legal) begin
      push({t, "_decode"}, mk(ST_D, F_NONE, 3'b000, 2'b00));
      for (int k = 0; k < 3; k++) push({t, "_trap"}, mk(ST_T, F_NONE, 3'b000, 2'b01));
    end else if (is_j) begin
      push({t, "_decode"}, mk(ST_D, F_JMP | F_PC | F_RET, 3'b000, 2'b00));
    end else begin
      push({t, "_decode"}, mk(ST_D, s, st_alu, 2'b00));
      if (is_beq) begin
        push({t, "_exec"}, mk(ST_E, F_PC | F_RET | (z ? F_SPC : F_NONE), 3'b110, 2'b00));
      end else begin
        push({t, "_exec"}, mk(ST_E, s, ex_alu, 2'b00));
        if (is_lw || is_sw)
          for (int k = 0; k <= dw; k++)
            push({t, "_mem"}, mk(ST_M, s | F_DREQ | (is_sw ? F_DWE : F_NONE) |
                                 ((is_sw && k == dw) ? (F_PC | F_RET) : F_NONE), st_alu, 2'b00));
        if (!is_sw) push({t, "_wb"}, mk(ST_W, s | F_RF | F_PC | F_RET, st_alu, 2'b00));
      end
    end

    instruction = ins;
    zero        = z;
    n           = exp_q.size();
    mem_start   = iw + 3;
    for (int c = 0; c < n; c++) begin
      // Readies are left high outside their windows; they must be ignored there
      ir = (c >= iw);
      dr = (is_lw || is_sw) ? ((c < mem_start) || (c >= mem_start + dw)) : 1'b1;
      step(ir, dr, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    instruction = 32'd0;
    zero        = 1'b0;
    imem_ready  = 1'b0;
    dmem_ready  = 1'b0;
    @(posedge clock);
    #1;
    push("reset_cycle", mk(ST_F, F_NONE, 3'b000, 2'b00));
    step(1'b0, 1'b0, 1'b1);

    run_instr("add",   r_ins(6'b100000), 0, 0, 1'b0);
    run_instr("lw_w3", i_ins(6'b100011), 0, 3, 1'b0);
    run_instr("sw",    i_ins(6'b101011), 1, 0, 1'b0);
    run_instr("sub",   r_ins(6'b100010), 0, 0, 1'b0);
    run_instr("and",   r_ins(6'b100100), 0, 0, 1'b1);
    run_instr("or",    r_ins(6'b100101), 0, 0, 1'b0);
    run_instr("slt",   r_ins(6'b101010), 0, 0, 1'b0);
    run_instr("addi_w3a", i_ins(6'b001000), 3, 0, 1'b0);
    run_instr("addi_w3b", i_ins(6'b001000), 3, 0, 1'b0);
    run_instr("beq_z1", i_ins(6'b000100), 0, 0, 1'b1);
    run_instr("beq_z0", i_ins(6'b000100), 0, 0, 1'b0);
    run_instr("j",     i_ins(6'b000010), 0, 0, 1'b0);
    run_instr("add_after_j", r_ins(6'b100000), 0, 0, 1'b0);

    run_instr("ill_op", i_ins(6'b111111), 0, 0, 1'b0);
    reset_cycle("reset_from_trap_ill", ST_T, 2'b01);
    run_instr("ill_fn", r_ins(6'b000000), 1, 0, 1'b0);
    reset_cycle("reset_from_trap_fn", ST_T, 2'b01);

    // Instruction memory never answers
    for (int k = 0; k < WL; k++) push("itimeout_fetch", mk(ST_F, F_IREQ, 3'b000, 2'b00));
    for (int k = 0; k < 3; k++)  push("itimeout_trap", mk(ST_T, F_NONE, 3'b000, 2'b10));
    for (int k = 0; k < WL + 3; k++) step(1'b0, 1'b1, 1'b0);
    reset_cycle("reset_from_timeout", ST_T, 2'b10);

    // Reset lands while a store is waiting in MEM
    instruction = i_ins(6'b101011);
    push("sw_abort_fetch",  mk(ST_F, F_IREQ, 3'b000, 2'b00));
    push("sw_abort_decode", mk(ST_D, F_ALUB, 3'b010, 2'b00));
    push("sw_abort_exec",   mk(ST_E, F_ALUB, 3'b010, 2'b00));
    push("sw_abort_mem",    mk(ST_M, F_ALUB | F_DREQ | F_DWE, 3'b010, 2'b00));
    push("sw_abort_mem",    mk(ST_M, F_ALUB | F_DREQ | F_DWE, 3'b010, 2'b00));
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push("reset_in_mem", mk(ST_M, F_NONE, 3'b000, 2'b00));
    step(1'b1, 1'b1, 1'b1);
    run_instr("add_after_abort", r_ins(6'b100000), 0, 0, 1'b0);

    // Data memory never answers a load
    instruction = i_ins(6'b100011);
    push("dtimeout_fetch",  mk(ST_F, F_IREQ, 3'b000, 2'b00));
    push("dtimeout_decode", mk(ST_D, F_ALUB | F_RES, 3'b010, 2'b00));
    push("dtimeout_exec",   mk(ST_E, F_ALUB | F_RES, 3'b010, 2'b00));
    for (int k = 0; k < WL; k++)
      push("dtimeout_mem", mk(ST_M, F_ALUB | F_RES | F_DREQ, 3'b010, 2'b00));
    for (int k = 0; k < 2; k++) push("dtimeout_trap", mk(ST_T, F_NONE, 3'b000, 2'b10));
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < WL + 2; k++) step(1'b1, 1'b0, 1'b0);
    reset_cycle("reset_from_dtimeout", ST_T, 2'b10);
    run_instr("add_final", r_ins(6'b100000), 0, 0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit that sequences the MIPS datapath one instruction at a time over FETCH/DECODE/EXEC/MEM/WB states, with req/ready handshakes to instruction and data memory. It decodes opcode/funct and drives every datapath select, the register-file write enable, the ALU control and a one-cycle PC-update enable. Illegal opcodes and memory timeouts stop it in a sticky trap state. It sits between the memories and the datapath; the datapath PC register is gated by `pc_en`.

## Interface
- `WAIT_LIMIT`, default 255: maximum cycles a memory request may wait for ready before a timeout trap (range 1..255).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instruction`  in  32  from imem; stable from the `imem_ready` cycle until the next `imem_req`.
- `zero`  in  1  ALU zero flag.
- `imem_ready`, `dmem_ready`  in  1 each  memory completion strobes.
- `imem_req`, `dmem_req`, `dmem_we`  out  1 each  memory requests; `dmem_we` is qualified by `dmem_req`.
- `pc_en`  out  1  one-cycle PC load enable.
- `rf_we`  out  1  one-cycle register-file write.
- `sel_result`, `sel_pc`, `sel_alu_b`, `sel_wa`, `sel_jump`  out  1 each  datapath mux selects.
- `alu_ctrl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `err`  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: hold `imem_req`=1. On `imem_ready`, latch opcode [31:26] and funct [5:0], then go to DECODE.
- DECODE:
  - Illegal opcode or funct goes to TRAP with `err`=01.
  - `j` (000010): `sel_jump`=1, `pc_en`=1, `retire`=1, go to FETCH.
  - All other legal instructions go to EXEC.
- EXEC: drive `alu_ctrl`.
  - `beq` (000100): `alu_ctrl`=110, `sel_pc`=`zero`, `pc_en`=1, `retire`=1, go to FETCH.
  - `lw`/`sw`: go to MEM.
  - R-type and `addi`: go to WB.
- MEM: hold `dmem_req`=1, with `dmem_we`=1 for `sw`. On `dmem_ready`:
  - `sw`: `pc_en`=1, `retire`=1, go to FETCH.
  - `lw`: go to WB.
- WB: `rf_we`=1, `pc_en`=1, `retire`=1, go to FETCH.
- Legal R-type funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Static selects come from the latched opcode and hold from DECODE through the last state of the instruction:
  - `sel_alu_b`=1 for `lw`/`sw`/`addi`.
  - `sel_wa`=1 for R-type.
  - `sel_result`=1 for `lw`.
  - `alu_ctrl`=010 for `lw`/`sw`/`addi`.
- `sel_pc` and `sel_jump` are 0 except in the cycles stated above.
- Wait counter: 8-bit, cleared on entry to FETCH or MEM, increments each cycle that ready is low. If it reaches `WAIT_LIMIT`, go to TRAP with `err`=10 and drop the request.
- TRAP: all outputs 0 except `err` and `state`. It is sticky; only `reset` exits.

## Timing
- Reset (any state, including mid-handshake): next cycle `state`=FETCH, `err`=00, counter=0. All strobes and selects are 0 in the reset cycle. `imem_req`=1 from the first post-reset cycle.
- Request rules:
  - A request rises on the cycle the state is entered and stays high until the cycle ready is sampled high.
  - It is low the following cycle.
  - A ready arriving while no request is outstanding is ignored.
- Minimum cycles per instruction, with ready in the first request cycle: j 2, beq 3, sw 4, R-type/addi 4, lw 5. Each wait cycle adds 1.
- `pc_en`, `rf_we` and `retire` are single-cycle and coincide in the final state of each instruction.
- Timeout: TRAP is entered exactly `WAIT_LIMIT` cycles after the request rises if ready never arrives. Ready in the same cycle the limit is hit counts as success.

## Structure
- Package `mips_pkg`: opcode constants, funct constants, `alu_ctrl` codes, state enum, `err` codes.
- Sub-module `alu_decoder`: combinational funct/opcode class to `alu_ctrl` plus an illegal flag. The FSM and wait counter live in the top.

## Test plan
- Reset, then `add` (opcode 0, funct 100000), readies immediate: `state` 0,1,2,4. `rf_we`=`pc_en`=`retire`=1 only in cycle 4; `sel_wa`=1; `alu_ctrl`=010.
- `lw` with `dmem_ready` delayed 3 cycles: `dmem_req` high for 4 cycles; 8 cycles total; `sel_result`=`sel_alu_b`=1; single `rf_we`.
- `beq` with `zero`=1, then `beq` with `zero`=0: 3 cycles each. `sel_pc`=1 with `pc_en` for the first, `sel_pc`=0 with `pc_en` for the second.
- `j`: `sel_jump`=`pc_en`=`retire`=1 in the DECODE cycle; next instruction fetched at cycle 3.
- Opcode 111111: TRAP, `err`=01, no `pc_en`. With `WAIT_LIMIT`=4 and `imem_ready` held low: TRAP after 4 cycles, `err`=10, `imem_req` low thereafter.
- Assert `reset` during MEM of `sw`: `dmem_req` low next cycle, `state`=FETCH, `err`=00, no `pc_en` or `retire`.
